mem_line_ctrl: RTL

MEM_LINE_CTRL -- requirements
Module: mem_line_ctrl

---
 rtl/mem_line_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_line_ctrl.sv
// Cache-line transfer controller: moves one LINE_BYTES line to or from memory as
// NBEAT bus beats over a shared command/data bus, with a response timeout.
module mem_line_ctrl #(
  parameter int ADDR_W     = 15,
  parameter int BUS_SIZE   = 16,
  parameter int LINE_BYTES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [LINE_BYTES*8-1:0] resp_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [1:0]              mem_cmd_out,
  output logic                    mem_cmd_oe,
  input  logic [1:0]              mem_cmd_in,
  output logic [BUS_SIZE-1:0]     mem_data_out,
  output logic                    mem_data_oe,
  input  logic [BUS_SIZE-1:0]     mem_data_in
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int NBEAT  = LINE_W / BUS_SIZE;
  localparam int LOW_W  = LINE_W - BUS_SIZE;
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    C2_NOP      = 2'd0,
    C2_RESPONSE = 2'd1,
    C2_READ     = 2'd2,
    C2_WRITE    = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    RD_BEAT,
    WR_BEAT,
    WR_WAIT,
    DONE
  } state_e;

  state_e              state, state_nx;
  logic [BEAT_W-1:0]   beat, beat_nx;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nx;
  logic                err, err_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LOW_W-1:0]    rd_buf;
  logic                accept;
  logic                mem_resp;
  logic                rd_capture;
  logic                rd_last;

  assign accept     = (state == IDLE) && req_valid;
  assign mem_resp   = (mem_cmd_in == C2_RESPONSE);
  // Beats 0..NBEAT-2 are buffered; the final beat goes straight into resp_rdata.
  assign rd_capture = ((state == RD_WAIT) && mem_resp) ||
                      ((state == RD_BEAT) && (beat != LAST_BEAT));
  assign rd_last    = (state == RD_BEAT) && (beat == LAST_BEAT);
  assign mem_addr   = addr_q;
  assign resp_err   = resp_valid & err;

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    beat_nx      = beat;
    wait_cnt_nx  = wait_cnt;
    err_nx       = err;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_cmd_out  = C2_NOP;
    mem_cmd_oe   = 1'b0;
    mem_data_oe  = 1'b0;
    mem_data_out = '0;

    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          err_nx   = 1'b0;
          beat_nx  = '0;
          state_nx = req_write ? WR_BEAT : RD_CMD;
        end
      end
      RD_CMD: begin
        mem_cmd_out = C2_READ;
        mem_cmd_oe  = 1'b1;
        wait_cnt_nx = '0;
        state_nx    = RD_WAIT;
      end
      RD_WAIT: begin
        // A response on the last allowed cycle still wins over the timeout.
        if (mem_resp) begin
          beat_nx  = BEAT_W'(1);
          state_nx = RD_BEAT;
        end else if (wait_cnt == CNT_MAX) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      RD_BEAT: begin
        if (beat == LAST_BEAT) state_nx = DONE;
        else                   beat_nx  = beat + 1'b1;
      end
      WR_BEAT: begin
        mem_cmd_out  = C2_WRITE;
        mem_cmd_oe   = 1'b1;
        mem_data_oe  = 1'b1;
        mem_data_out = wdata_q[beat*BUS_SIZE +: BUS_SIZE];
        if (beat == LAST_BEAT) begin
          wait_cnt_nx = '0;
          state_nx    = WR_WAIT;
        end else begin
          beat_nx = beat + 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_resp) begin
          state_nx = DONE;
        end else if (wait_cnt == CNT_MAX) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat       <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
      addr_q     <= '0;
      resp_rdata <= '0;
    end else begin
      state    <= state_nx;
      beat     <= beat_nx;
      wait_cnt <= wait_cnt_nx;
      err      <= err_nx;
      if (accept)  addr_q     <= req_addr;
      if (rd_last) resp_rdata <= {mem_data_in, rd_buf};
    end
  end

  // NOTE: line data buffers are not reset; they are always written before being
  // read, and dropping the reset keeps the wide registers cheap.
  always_ff @(posedge clk) begin
    if (accept)     wdata_q <= req_wdata;
    if (rd_capture) rd_buf  <= {mem_data_in, rd_buf[LOW_W-1:BUS_SIZE]};
  end

endmodule
